vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 168 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator.
// Divides i_clk down to a pixel tick and runs horizontal/vertical counters. It produces
// registered strobes that line up with the counter values they describe, plus sync and
// blank pins that are delayed to match the colour pipeline.
//
// Ports:
//   i_clk            system clock (only clock)
//   i_reset          synchronous active-high reset
//   o_hsync          high while h_count >= H_ACTIVE
//   o_vsync          one-cycle pulse when v_count becomes V_ACTIVE
//   o_screen_reset   one-cycle pulse when (h,v) becomes (0,0), and once after reset release
//   o_pixel_x_clock  one-cycle enable every X_DIV active pixels
//   o_pixel_y_clock  one-cycle enable when an active line ends
//   o_x, o_y         current h_count / v_count
//   o_hs_n, o_vs_n   active-low sync pins, delayed by PIPE_DELAY cycles
//   o_blank_n        active-video flag, delayed by PIPE_DELAY cycles
module vga_timing_gen #(
    parameter int unsigned CLK_PER_PIXEL = 4,
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FP          = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FP          = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BP          = 33,
    parameter int unsigned X_DIV         = 2,
    parameter int unsigned PIPE_DELAY    = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_screen_reset,
    output logic       o_pixel_x_clock,
    output logic       o_pixel_y_clock,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_hs_n,
    output logic       o_vs_n,
    output logic       o_blank_n
);

    localparam int unsigned DIV_W = (CLK_PER_PIXEL > 1) ? $clog2(CLK_PER_PIXEL) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_PER_PIXEL - 1);

    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_DIV_L   = 10'(X_DIV);
    localparam logic [9:0] X_LAST    = 10'(X_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             sr_q, sr_d;
    logic             xclk_q, xclk_d;
    logic             yclk_q, yclk_d;
    logic             rst_seen_q;
    logic             tick;
    logic             h_wrap;
    logic             active_d;
    logic             hs_raw, vs_raw, blank_raw;

    // Strobes are computed from next-state counters so that, once registered, each one is
    // high in the same cycle that o_x/o_y show the value it describes.
    always_comb begin
        tick     = (div_q == DIV_MAX);
        h_wrap   = (h_q == H_LAST);
        div_d    = tick ? '0 : div_q + 1'b1;
        h_d      = h_q;
        v_d      = v_q;
        if (tick) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            if (h_wrap) begin
                v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
            end
        end
        active_d = (h_d < H_ACT) && (v_d < V_ACT);
        xclk_d   = tick && active_d && ((h_d % X_DIV_L) == X_LAST);
        yclk_d   = tick && (h_d == H_ACT) && (v_d < V_ACT);
        vsync_d  = tick && h_wrap && (v_d == V_ACT);
        // rst_seen_q yields the extra screen-reset pulse right after release.
        sr_d     = rst_seen_q || (tick && (h_d == 10'd0) && (v_d == 10'd0));
        hsync_d  = (h_d >= H_ACT);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_q      <= '0;
            h_q        <= '0;
            v_q        <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            sr_q       <= 1'b0;
            xclk_q     <= 1'b0;
            yclk_q     <= 1'b0;
            rst_seen_q <= 1'b1;
        end else begin
            div_q      <= div_d;
            h_q        <= h_d;
            v_q        <= v_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            sr_q       <= sr_d;
            xclk_q     <= xclk_d;
            yclk_q     <= yclk_d;
            rst_seen_q <= 1'b0;
        end
    end

    always_comb begin
        hs_raw    = !((h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI));
        vs_raw    = !((v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI));
        blank_raw = (h_q < H_ACT) && (v_q < V_ACT);
    end

    generate
        if (PIPE_DELAY == 0) begin : g_no_pipe
            // Counters read zero during reset, which would look active; force idle levels.
            assign o_hs_n    = i_reset | hs_raw;
            assign o_vs_n    = i_reset | vs_raw;
            assign o_blank_n = ~i_reset & blank_raw;
        end else begin : g_pipe
            logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
            logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
            logic [PIPE_DELAY-1:0] bl_pipe_q, bl_pipe_d;

            always_comb begin
                hs_pipe_d = (hs_pipe_q << 1) | PIPE_DELAY'(hs_raw);
                vs_pipe_d = (vs_pipe_q << 1) | PIPE_DELAY'(vs_raw);
                bl_pipe_d = (bl_pipe_q << 1) | PIPE_DELAY'(blank_raw);
            end

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    hs_pipe_q <= '1;
                    vs_pipe_q <= '1;
                    bl_pipe_q <= '0;
                end else begin
                    hs_pipe_q <= hs_pipe_d;
                    vs_pipe_q <= vs_pipe_d;
                    bl_pipe_q <= bl_pipe_d;
                end
            end

            assign o_hs_n    = hs_pipe_q[PIPE_DELAY-1];
            assign o_vs_n    = vs_pipe_q[PIPE_DELAY-1];
            assign o_blank_n = bl_pipe_q[PIPE_DELAY-1];
        end
    endgenerate

    assign o_hsync         = hsync_q;
    assign o_vsync         = vsync_q;
    assign o_screen_reset  = sr_q;
    assign o_pixel_x_clock = xclk_q;
    assign o_pixel_y_clock = yclk_q;
    assign o_x             = h_q;
    assign o_y             = v_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing (line-level), tiny CLK_PER_PIXEL=1
// geometry (cycle-exact table), and a small CLK_PER_PIXEL=4 geometry (full-frame counts).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

    logic       a_hsync, a_vsync, a_sr, a_xs, a_ys, a_hs_n, a_vs_n, a_blank_n;
    logic [9:0] a_x, a_y;
    logic       b_hsync, b_vsync, b_sr, b_xs, b_ys, b_hs_n, b_vs_n, b_blank_n;
    logic [9:0] b_x, b_y;
    logic       c_hsync, c_vsync, c_sr, c_xs, c_ys, c_hs_n, c_vs_n, c_blank_n;
    logic [9:0] c_x, c_y;

    vga_timing_gen dut_a (
        .i_clk(clk), .i_reset(rst_a), .o_hsync(a_hsync), .o_vsync(a_vsync),
        .o_screen_reset(a_sr), .o_pixel_x_clock(a_xs), .o_pixel_y_clock(a_ys),
        .o_x(a_x), .o_y(a_y), .o_hs_n(a_hs_n), .o_vs_n(a_vs_n), .o_blank_n(a_blank_n)
    );

    vga_timing_gen #(
        .CLK_PER_PIXEL(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .X_DIV(2), .PIPE_DELAY(2)
    ) dut_b (
        .i_clk(clk), .i_reset(rst_b), .o_hsync(b_hsync), .o_vsync(b_vsync),
        .o_screen_reset(b_sr), .o_pixel_x_clock(b_xs), .o_pixel_y_clock(b_ys),
        .o_x(b_x), .o_y(b_y), .o_hs_n(b_hs_n), .o_vs_n(b_vs_n), .o_blank_n(b_blank_n)
    );

    vga_timing_gen #(
        .CLK_PER_PIXEL(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .X_DIV(2), .PIPE_DELAY(5)
    ) dut_c (
        .i_clk(clk), .i_reset(rst_c), .o_hsync(c_hsync), .o_vsync(c_vsync),
        .o_screen_reset(c_sr), .o_pixel_x_clock(c_xs), .o_pixel_y_clock(c_ys),
        .o_x(c_x), .o_y(c_y), .o_hs_n(c_hs_n), .o_vs_n(c_vs_n), .o_blank_n(c_blank_n)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed view: {x, y, xs, ys, vsync, sr, hsync, hs_n, vs_n, blank_n}
    localparam logic [27:0] IDLE = {10'd0, 10'd0, 5'b00000, 3'b110};

    typedef struct {
        int         k;
        logic [9:0] x, y;
        logic       xs, ys, vs, sr, hsync, hs_n, vs_n, blank_n;
    } vec_t;

    vec_t tbl[22];

    initial begin
        int e, xs_cnt, ys_cnt, ys_edge, hsy_edge, hs_first, hs_low, bl_high, sr_cnt;
        int cb, t0, t1, vs_cnt, vs_low;
        logic [27:0] got, exp;

        // Edge k after release of dut_b: pins show raw state from edge k-2.
        tbl[0]  = '{1,  10'd1, 10'd0, 1, 0, 0, 1, 0, 1, 1, 0};
        tbl[1]  = '{2,  10'd2, 10'd0, 0, 0, 0, 0, 0, 1, 1, 1};
        tbl[2]  = '{3,  10'd3, 10'd0, 1, 0, 0, 0, 0, 1, 1, 1};
        tbl[3]  = '{4,  10'd4, 10'd0, 0, 1, 0, 0, 1, 1, 1, 1};
        tbl[4]  = '{5,  10'd5, 10'd0, 0, 0, 0, 0, 1, 1, 1, 1};
        tbl[5]  = '{6,  10'd6, 10'd0, 0, 0, 0, 0, 1, 1, 1, 0};
        tbl[6]  = '{7,  10'd0, 10'd1, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[7]  = '{8,  10'd1, 10'd1, 1, 0, 0, 0, 0, 1, 1, 0};
        tbl[8]  = '{9,  10'd2, 10'd1, 0, 0, 0, 0, 0, 1, 1, 1};
        tbl[9]  = '{15, 10'd1, 10'd2, 1, 0, 0, 0, 0, 1, 1, 0};
        tbl[10] = '{18, 10'd4, 10'd2, 0, 1, 0, 0, 1, 1, 1, 1};
        tbl[11] = '{21, 10'd0, 10'd3, 0, 0, 1, 0, 0, 0, 1, 0};
        tbl[12] = '{22, 10'd1, 10'd3, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[13] = '{25, 10'd4, 10'd3, 0, 0, 0, 0, 1, 1, 1, 0};
        tbl[14] = '{30, 10'd2, 10'd4, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[15] = '{36, 10'd1, 10'd5, 0, 0, 0, 0, 0, 1, 0, 0};
        tbl[16] = '{37, 10'd2, 10'd5, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[17] = '{41, 10'd6, 10'd5, 0, 0, 0, 0, 1, 1, 1, 0};
        tbl[18] = '{42, 10'd0, 10'd0, 0, 0, 0, 1, 0, 0, 1, 0};
        tbl[19] = '{43, 10'd1, 10'd0, 1, 0, 0, 0, 0, 1, 1, 0};
        tbl[20] = '{44, 10'd2, 10'd0, 0, 0, 0, 0, 0, 1, 1, 1};
        tbl[21] = '{46, 10'd4, 10'd0, 0, 1, 0, 0, 1, 1, 1, 1};

        // ---------------- default geometry ----------------
        repeat (3) step();
        chk("a_reset_state", {a_x, a_y, a_xs, a_ys, a_vsync, a_sr, a_hsync, a_hs_n, a_vs_n,
                              a_blank_n}, IDLE);
        rst_a = 1'b0;
        step();
        chk("a_sr_after_release", a_sr, 1);
        chk("a_x_edge1", a_x, 0);
        step();
        chk("a_sr_edge2", a_sr, 0);
        chk("a_x_edge2", a_x, 0);
        step();
        chk("a_x_edge3", a_x, 0);
        step();
        chk("a_first_tick_x", a_x, 1);
        chk("a_first_xstrobe", a_xs, 1);
        xs_cnt = 1; ys_cnt = 0; ys_edge = -1; hsy_edge = -1; hs_first = -1;
        hs_low = 0; bl_high = 0;
        for (e = 5; e <= 3200; e++) begin
            step();
            if (a_xs) xs_cnt++;
            if (a_ys) begin ys_cnt++; ys_edge = e; end
            if (a_hsync && hsy_edge < 0) hsy_edge = e;
            if (!a_hs_n) begin hs_low++; if (hs_first < 0) hs_first = e; end
            if (a_blank_n) bl_high++;
        end
        chk("a_line0_xstrobes", xs_cnt, 320);
        chk("a_line0_ystrobes", ys_cnt, 1);
        chk("a_ystrobe_edge", ys_edge, 2560);
        chk("a_hsync_rise_edge", hsy_edge, 2560);
        chk("a_hs_n_fall_edge", hs_first, 656 * 4 + 5);
        chk("a_hs_n_low_cycles", hs_low, 384);
        chk("a_blank_n_high_cycles", bl_high, 640 * 4);
        chk("a_line1_start", {a_x, a_y}, {10'd0, 10'd1});
        for (e = 3201; e <= 4400; e++) step();
        chk("a_mid_pos", {a_x, a_y}, {10'd300, 10'd1});
        rst_a = 1'b1;
        step();
        chk("a_midframe_reset", {a_x, a_y, a_xs, a_ys, a_vsync, a_sr, a_hsync, a_hs_n, a_vs_n,
                                 a_blank_n}, IDLE);
        step();
        rst_a = 1'b0;
        sr_cnt = 0;
        for (e = 1; e <= 8; e++) begin
            step();
            if (a_sr) sr_cnt++;
            if (e == 3) chk("a_rel2_x_edge3", a_x, 0);
            if (e == 4) chk("a_rel2_x_edge4", a_x, 1);
        end
        chk("a_rel2_sr_count", sr_cnt, 1);
        rst_a = 1'b1;

        // ---------------- tiny geometry, cycle-exact ----------------
        chk("b_reset_state", {b_x, b_y, b_xs, b_ys, b_vsync, b_sr, b_hsync, b_hs_n, b_vs_n,
                              b_blank_n}, IDLE);
        rst_b = 1'b0;
        cb = 0;
        for (int i = 0; i < 22; i++) begin
            while (cb < tbl[i].k) begin
                step();
                cb++;
            end
            got = {b_x, b_y, b_xs, b_ys, b_vsync, b_sr, b_hsync, b_hs_n, b_vs_n, b_blank_n};
            exp = {tbl[i].x, tbl[i].y, tbl[i].xs, tbl[i].ys, tbl[i].vs, tbl[i].sr,
                   tbl[i].hsync, tbl[i].hs_n, tbl[i].vs_n, tbl[i].blank_n};
            chk($sformatf("b_vec_k%0d", tbl[i].k), got, exp);
        end
        rst_b = 1'b1;

        // ---------------- small geometry, full frame ----------------
        step();
        rst_c = 1'b0;
        t0 = -1;
        for (e = 1; e <= 2000 && t0 < 0; e++) begin
            step();
            if (c_sr && e > 1) t0 = e;
        end
        chk("c_first_frame_edge", t0, 448);
        t1 = -1; xs_cnt = 0; ys_cnt = 0; vs_cnt = 0; vs_low = 0; hs_low = 0; bl_high = 0;
        for (e = 1; e <= 1000 && t1 < 0; e++) begin
            step();
            if (c_xs) xs_cnt++;
            if (c_ys) ys_cnt++;
            if (c_vsync) vs_cnt++;
            if (!c_vs_n) vs_low++;
            if (!c_hs_n) hs_low++;
            if (c_blank_n) bl_high++;
            if (c_sr) t1 = e;
        end
        chk("c_frame_period", t1, 448);
        chk("c_xstrobes", xs_cnt, 16);
        chk("c_ystrobes", ys_cnt, 4);
        chk("c_vsync_pulses", vs_cnt, 1);
        chk("c_vs_n_low_cycles", vs_low, 112);
        chk("c_hs_n_low_cycles", hs_low, 64);
        chk("c_blank_n_high_cycles", bl_high, 128);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
